// File: rtl/fetch_pkg.sv
// Types and constants shared by the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
module ifid_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  i_load,
  input  logic                  i_kill,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_plus4,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_pc_plus4;
  logic                  r_valid;

  // Load has priority; a kill drops the slot to a NOP bubble but keeps the PCs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= {DATA_WIDTH{1'b0}};
      r_pc_plus4 <= {DATA_WIDTH{1'b0}};
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end else if (i_kill) begin
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem FSM, one-entry
// hold buffer for responses that land while decode is stalled.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  PCSrc_i,
  input  logic [DATA_WIDTH-1:0] PCTarget_i,
  input  logic                  Stall_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PCPlus4_o,
  output logic                  Valid_o
);

  import fetch_pkg::*;

  localparam logic [DATA_WIDTH-1:0] PC_STEP    = {{(DATA_WIDTH-3){1'b0}}, 3'd4};
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  fetch_state_t          r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                  r_hold_valid;
  logic [DATA_WIDTH-1:0] r_hold_instr, r_hold_pc;

  logic                  w_valid, w_accept, w_req;
  logic                  w_load, w_kill, w_hold_set, w_hold_clr;
  logic [DATA_WIDTH-1:0] w_addr, w_target, w_pc_plus4, w_hold_pc_plus4;
  logic [DATA_WIDTH-1:0] w_ld_instr, w_ld_pc, w_ld_pc_plus4;

  assign w_accept        = !w_valid || !Stall_i;
  assign w_target        = PCTarget_i & ALIGN_MASK;
  assign w_pc_plus4      = r_pc + PC_STEP;
  assign w_hold_pc_plus4 = r_hold_pc + PC_STEP;

  // Next-state, PC, request and IF/ID control; a redirect overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_req         = 1'b0;
    w_addr        = r_pc;
    w_load        = 1'b0;
    w_kill        = 1'b0;
    w_hold_set    = 1'b0;
    w_hold_clr    = 1'b0;
    w_ld_instr    = imem_rdata_i;
    w_ld_pc       = r_pc;
    w_ld_pc_plus4 = w_pc_plus4;
    if (PCSrc_i) begin
      w_pc_nxt   = w_target;
      w_kill     = 1'b1;
      w_hold_clr = 1'b1;
      case (r_state)
        WAIT, DISCARD: w_state_nxt = imem_rvalid_i ? IDLE : DISCARD;
        default:       w_state_nxt = IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && r_hold_valid) begin
            w_load        = 1'b1;
            w_ld_instr    = r_hold_instr;
            w_ld_pc       = r_hold_pc;
            w_ld_pc_plus4 = w_hold_pc_plus4;
            w_pc_nxt      = w_hold_pc_plus4;
            w_hold_clr    = 1'b1;
          end else if (w_accept) begin
            w_req       = 1'b1;
            w_state_nxt = WAIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WAIT: begin
          if (imem_rvalid_i && w_accept) begin
            w_load   = 1'b1;
            w_pc_nxt = w_pc_plus4;
            w_req    = 1'b1;
            w_addr   = w_pc_plus4;
          end else if (imem_rvalid_i) begin
            w_hold_set  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT;
          end
        end
        DISCARD: w_state_nxt = imem_rvalid_i ? IDLE : DISCARD;
        default: w_state_nxt = IDLE;
      endcase
      w_kill = w_valid && !Stall_i && !w_load;
    end
  end

  // PC, FSM state and hold buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_hold_valid <= 1'b0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_hold_clr) begin
        r_hold_valid <= 1'b0;
      end else if (w_hold_set) begin
        r_hold_valid <= 1'b1;
        r_hold_instr <= imem_rdata_i;
        r_hold_pc    <= r_pc;
      end
    end
  end

  // The FSM idles in IDLE during reset, so the request is masked explicitly.
  assign imem_req_o  = w_req && rst_n_i;
  assign imem_addr_o = w_addr;

  ifid_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_ifid (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .i_load     (w_load),
    .i_kill     (w_kill),
    .i_instr    (w_ld_instr),
    .i_pc       (w_ld_pc),
    .i_pc_plus4 (w_ld_pc_plus4),
    .o_instr    (Instr_o),
    .o_pc       (PC_o),
    .o_pc_plus4 (PCPlus4_o),
    .o_valid    (w_valid)
  );

  assign Valid_o = w_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model, in-order delivery scoreboard
// and hand-computed per-cycle expectations.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcsrc = 1'b0, stall = 1'b0;
  logic [31:0] target = 32'h0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        req, valid;
  logic [31:0] addr, instr, pc, pc4;

  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pc4_2;

  int          n_vec = 0, n_err = 0;
  int          lat = 1;
  logic [31:0] key = 32'h0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] maddr = 32'h0;

  logic        s_req, s_valid, s_req2, s_valid2;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4, s_addr2, s_pc2, s_pc4_2;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .PCSrc_i(pcsrc), .PCTarget_i(target), .Stall_i(stall),
    .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .Instr_o(instr), .PC_o(pc), .PCPlus4_o(pc4), .Valid_o(valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .PCSrc_i(1'b0), .PCTarget_i(32'h0), .Stall_i(1'b0),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .Instr_o(instr2), .PC_o(pc2), .PCPlus4_o(pc4_2), .Valid_o(valid2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: capture outputs mid-cycle, then advance the memory models.
  task automatic step();
    @(negedge clk);
    s_req = req; s_addr = addr; s_valid = valid; s_instr = instr; s_pc = pc; s_pc4 = pc4;
    s_req2 = req2; s_addr2 = addr2; s_valid2 = valid2; s_pc2 = pc2; s_pc4_2 = pc4_2;
    @(posedge clk);
    #1;
    if (s_req) begin
      chk("one_outstanding", {31'b0, busy}, 32'd0);
      busy = 1'b1; cnt = lat; maddr = s_addr;
    end
    rvalid = 1'b0;
    rdata  = 32'hDEAD_BEEF;
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        rvalid = 1'b1; rdata = maddr ^ key; busy = 1'b0;
      end
    end
    rvalid2 = s_req2;
    rdata2  = s_req2 ? s_addr2 : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset(input int ncyc, input int new_lat, input logic [31:0] new_key);
    rst_n = 1'b0; pcsrc = 1'b0; stall = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      chk("rst_req", {31'b0, s_req}, 32'd0);
      chk("rst_valid", {31'b0, s_valid}, 32'd0);
      chk("rst_instr", s_instr, NOP);
      chk("rst_pc", s_pc, 32'd0);
      chk("rst_pc4", s_pc4, 32'd0);
    end
    busy = 1'b0; rvalid = 1'b0; lat = new_lat; key = new_key;
    rst_n = 1'b1;
  endtask

  // Model: IF/ID contents must match memory, stalls hold, redirects flush,
  // and consumed instructions form one gap-free, duplicate-free PC stream.
  logic [31:0] m_exp_pc = 32'h0, m_held_pc = 32'h0, m_held_instr = 32'h0;
  logic        m_flush = 1'b0, m_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_exp_pc <= 32'h0; m_flush <= 1'b0; m_hold <= 1'b0;
    end else begin
      if (!valid) chk("nop_when_empty", instr, NOP);
      else begin
        chk("instr_matches_pc", instr, pc ^ key);
        chk("pcplus4", pc4, pc + 32'd4);
      end
      if (m_flush) chk("flush_after_redirect", {31'b0, valid}, 32'd0);
      if (m_hold) begin
        chk("stall_holds_valid", {31'b0, valid}, 32'd1);
        chk("stall_holds_pc", pc, m_held_pc);
        chk("stall_holds_instr", instr, m_held_instr);
      end
      if (valid && !stall && !pcsrc) chk("in_order_pc", pc, m_exp_pc);
      if (req) chk("addr_aligned", {30'b0, addr[1:0]}, 32'd0);
      m_flush      <= pcsrc;
      m_hold       <= valid && stall && !pcsrc;
      m_held_pc    <= pc;
      m_held_instr <= instr;
      if (pcsrc) m_exp_pc <= target & 32'hFFFF_FFFC;
      else if (valid && !stall) m_exp_pc <= m_exp_pc + 32'd4;
    end
  end

  initial begin
    // Streaming after reset, word = address; wrap instance starts near the top.
    do_reset(3, 1, 32'h0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t1_req", {31'b0, s_req}, 32'd1);
      chk("t1_addr", s_addr, 32'(4 * k));
      case (k)
        0: chk("wrap_addr0", s_addr2, 32'hFFFF_FFF8);
        1: begin chk("t1_valid1", {31'b0, s_valid}, 32'd0); chk("wrap_addr1", s_addr2, 32'hFFFF_FFFC); end
        2: begin chk("t1_valid2", {31'b0, s_valid}, 32'd1); chk("t1_pc2", s_pc, 32'h0);
                 chk("wrap_addr2", s_addr2, 32'h0); chk("wrap_pc2", s_pc2, 32'hFFFF_FFF8); end
        3: begin chk("t1_pc3", s_pc, 32'h4); chk("t1_instr3", s_instr, 32'h4); chk("t1_pc4_3", s_pc4, 32'h8);
                 chk("wrap_pc3", s_pc2, 32'hFFFF_FFFC); chk("wrap_pc4_3", s_pc4_2, 32'h0); end
        4: begin chk("t1_pc4", s_pc, 32'h8); chk("wrap_pc4", s_pc2, 32'h0); chk("wrap_valid4", {31'b0, s_valid2}, 32'd1); end
        default: ;
      endcase
    end

    // Stall while the response for 0x8 is in flight.
    do_reset(2, 1, 32'h1234_0000);
    for (int k = 0; k < 12; k++) begin
      stall = (k >= 3 && k <= 5);
      step();
      if (k >= 3 && k <= 6) chk("t2_no_req", {31'b0, s_req}, 32'd0);
      case (k)
        4:  begin chk("t2_valid4", {31'b0, s_valid}, 32'd1); chk("t2_pc4", s_pc, 32'h4); end
        7:  begin chk("t2_req7", {31'b0, s_req}, 32'd1); chk("t2_addr7", s_addr, 32'hC);
                  chk("t2_pc7", s_pc, 32'h8); chk("t2_instr7", s_instr, 32'h1234_0008); end
        8:  chk("t2_valid8", {31'b0, s_valid}, 32'd0);
        9:  chk("t2_pc9", s_pc, 32'hC);
        10: chk("t2_pc10", s_pc, 32'h10);
        default: ;
      endcase
    end
    stall = 1'b0;

    // Redirect to an unaligned target while a request is outstanding.
    do_reset(2, 2, 32'h5A5A_0000);
    for (int k = 0; k < 12; k++) begin
      pcsrc  = (k == 5);
      target = 32'h0000_0103;
      step();
      case (k)
        2:  chk("t3_addr2", s_addr, 32'h4);
        5:  chk("t3_req5", {31'b0, s_req}, 32'd0);
        6:  begin chk("t3_valid6", {31'b0, s_valid}, 32'd0); chk("t3_req6", {31'b0, s_req}, 32'd0); end
        7:  begin chk("t3_req7", {31'b0, s_req}, 32'd1); chk("t3_addr7", s_addr, 32'h100); end
        9:  chk("t3_valid9", {31'b0, s_valid}, 32'd0);
        10: begin chk("t3_pc10", s_pc, 32'h100); chk("t3_instr10", s_instr, 32'h5A5A_0100);
                  chk("t3_pc4_10", s_pc4, 32'h104); end
        default: ;
      endcase
    end
    pcsrc = 1'b0;

    // Redirect, stall and response all in the same cycle.
    do_reset(2, 1, 32'h0F0F_0000);
    for (int k = 0; k < 9; k++) begin
      pcsrc  = (k == 3);
      stall  = (k == 3);
      target = 32'h0000_0200;
      step();
      case (k)
        3: chk("t4_req3", {31'b0, s_req}, 32'd0);
        4: begin chk("t4_valid4", {31'b0, s_valid}, 32'd0); chk("t4_req4", {31'b0, s_req}, 32'd1);
                 chk("t4_addr4", s_addr, 32'h200); end
        5: chk("t4_valid5", {31'b0, s_valid}, 32'd0);
        6: begin chk("t4_pc6", s_pc, 32'h200); chk("t4_instr6", s_instr, 32'h0F0F_0200); end
        default: ;
      endcase
    end
    pcsrc = 1'b0; stall = 1'b0;

    // Reset with a request outstanding; its response arrives during reset.
    do_reset(2, 3, 32'h7777_0000);
    step();
    chk("t6_req0", {31'b0, s_req}, 32'd1);
    do_reset(4, 1, 32'h3C3C_0000);
    for (int k = 0; k < 4; k++) begin
      step();
      case (k)
        0: begin chk("t6_req_after", {31'b0, s_req}, 32'd1); chk("t6_addr_after", s_addr, 32'h0); end
        1: chk("t6_valid1", {31'b0, s_valid}, 32'd0);
        2: begin chk("t6_pc2", s_pc, 32'h0); chk("t6_instr2", s_instr, 32'h3C3C_0000); end
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core, directly upstream of decode and the control unit. It owns the PC register and issues requests to the instruction memory, allowing at most one outstanding request. It handles PC redirects from taken branches and jumps, and drives the IF/ID pipeline register that presents `Instr_o` to the decoder. A one-entry hold buffer absorbs a memory response that arrives while decode is stalled.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the PC and the instruction.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013 (`addi x0,x0,0`), value of `Instr_o` whenever `Valid_o`=0.

Ports:
- `clk_i`  in  1  core clock.
- `rst_n_i`  in  1  reset, asynchronous and active-low.
- `PCSrc_i`  in  1  redirect request (taken branch / jal / jalr).
- `PCTarget_i`  in  DATA_WIDTH  redirect address; bits [1:0] are ignored and forced to 0.
- `Stall_i`  in  1  decode cannot accept; IF/ID holds.
- `imem_req_o`  out  1  instruction memory read request, one cycle per request.
- `imem_addr_o`  out  DATA_WIDTH  request address, word-aligned.
- `imem_rvalid_i`  in  1  response valid, one cycle, at least 1 cycle after the request.
- `imem_rdata_i`  in  DATA_WIDTH  response instruction.
- `Instr_o`  out  DATA_WIDTH  IF/ID instruction.
- `PC_o`  out  DATA_WIDTH  IF/ID PC.
- `PCPlus4_o`  out  DATA_WIDTH  IF/ID PC+4.
- `Valid_o`  out  1  IF/ID holds a real instruction.

## Operation
- State machine states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - DISCARD: request outstanding, response to be dropped.
- Registers: `pc_q`, state, IF/ID (`Instr_o`, `PC_o`, `PCPlus4_o`, `Valid_o`), hold buffer (`hold_valid`, `hold_instr`, `hold_pc`).
- Define `accept = !Valid_o || !Stall_i`, meaning IF/ID may load this cycle.
- Redirect (`PCSrc_i`=1) has highest priority in every state:
  - `pc_q`←{`PCTarget_i`[31:2],2'b00}.
  - `Valid_o`←0, `Instr_o`←`NOP_INSTR`, `hold_valid`←0.
  - No request is issued that cycle.
  - From WAIT: go to DISCARD, or to IDLE if `imem_rvalid_i`=1 that same cycle (the response is dropped).
  - From DISCARD: stay in DISCARD, or go to IDLE on `imem_rvalid_i`.
  - From IDLE: stay in IDLE.
- IDLE:
  - If `hold_valid` && `accept`: move the hold buffer into IF/ID, `pc_q`←`hold_pc`+4, `hold_valid`←0.
  - If `!hold_valid` && `accept`: `imem_req_o`=1, `imem_addr_o`=`pc_q`, go to WAIT.
- WAIT on `imem_rvalid_i`:
  - If `accept`: IF/ID←{`imem_rdata_i`, `pc_q`, `pc_q`+4}, `Valid_o`←1, `pc_q`←`pc_q`+4. Issue the next request in the same cycle (`imem_addr_o`=`pc_q`+4) and stay in WAIT.
  - Else: hold buffer←{`imem_rdata_i`, `pc_q`}, `hold_valid`←1, go to IDLE.
- DISCARD on `imem_rvalid_i`: drop the response, go to IDLE.
- IF/ID with `Valid_o` && !`Stall_i` and nothing new to load: `Valid_o`←0, `Instr_o`←`NOP_INSTR`.
- Arithmetic: PC+4 is modulo 2^DATA_WIDTH. 32'hFFFF_FFFC wraps to 0 with no flag.
- `imem_req_o` is combinational from state, `hold_valid`, `accept`, `PCSrc_i` and `imem_rvalid_i`. All other outputs are registered.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `pc_q`=`RESET_PC`, `Valid_o`=0, `Instr_o`=`NOP_INSTR`, `PC_o`=0, `PCPlus4_o`=0, `hold_valid`=0, `imem_req_o`=0 while `rst_n_i`=0.
- Reset mid-request: the outstanding request is forgotten. A late `imem_rvalid_i` in IDLE is ignored.
- First request is issued in the first cycle after reset release.
- Request in cycle N with 1-cycle memory: `Valid_o`=1 at N+2. Steady-state throughput is 1 instruction per cycle.
- Redirect in cycle N: request to the target in N+1 if IDLE; otherwise it follows the discarded response.
- Redirect + `Stall_i` + `imem_rvalid_i` all in one cycle: redirect wins, IF/ID is flushed, and the response is dropped.
- No instruction is lost or duplicated across a stall.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum {IDLE, WAIT, DISCARD}.
  - `NOP_INSTR` constant.
  - `RESET_PC` default.
- Natural sub-module: `ifid_reg` (IF/ID register with load/flush/valid).
- The PC register, FSM and hold buffer stay in `fetch_stage`.

## Test plan
- Reset release, 1-cycle memory returning word = address: `imem_addr_o` runs 0,4,8,… on consecutive cycles. `Valid_o`=1 from cycle 2, `PC_o`/`Instr_o` advance by 4 each cycle.
- `Stall_i`=1 for 3 cycles while a response is in flight: the response lands in the hold buffer and no request is issued. On release, the instructions at 0x8, 0xC, 0x10 appear in order with no gap in PC sequence and no duplicates.
- `PCSrc_i`=1 with `PCTarget_i`=32'h0000_0103 while in WAIT: the next response is dropped, `Valid_o`=0 for that slot, the next request address is 0x100, and `PC_o` becomes 0x100.
- Redirect, `Stall_i` and `imem_rvalid_i` in the same cycle: `Valid_o`=0 next cycle, `hold_valid`=0, and the fetch restarts at the target.
- `RESET_PC`=32'hFFFF_FFF8: PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, with `PCPlus4_o`=0 for the second.
- Assert `rst_n_i` with a request outstanding and return `imem_rvalid_i` during reset: all outputs are at reset values, and the first post-reset request is to `RESET_PC`.
